// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline boundary: RV32I load alignment/extension, writeback source
// selection, load-fault detection and a retired-instruction counter.
module mem_wb_stage #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 in_valid,
  input  logic [31:0]          alu_result,
  input  logic [31:0]          mem_read_data,
  input  logic [31:0]          pc_plus4,
  input  logic [4:0]           rd_addr,
  input  logic                 reg_write,
  input  logic [1:0]           wb_sel,
  input  logic [2:0]           funct3,
  output logic                 wb_valid,
  output logic                 wb_we,
  output logic [4:0]           wb_rd,
  output logic [31:0]          wb_data,
  output logic                 load_fault,
  output logic [CNT_WIDTH-1:0] retire_count
);

  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_PC4  = 2'b10;

  // Illegal load code, or an access not naturally aligned to its size.
  function automatic logic load_is_fault(input logic [2:0] f3, input logic [1:0] off);
    logic res;
    res = 1'b1;
    case (f3)
      3'b000, 3'b100: res = 1'b0;
      3'b001, 3'b101: res = off[0];
      3'b010:         res = (off != 2'b00);
      default:        res = 1'b1;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] extract_load(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b   = 8'h00;
    res = 32'h0000_0000;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = 8'h00;
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  res = {{24{b[7]}}, b};
      3'b100:  res = {24'h00_0000, b};
      3'b001:  res = {{16{h[15]}}, h};
      3'b101:  res = {16'h0000, h};
      3'b010:  res = word;
      default: res = 32'h0000_0000;
    endcase
    return res;
  endfunction

  logic        fault;
  logic [31:0] next_data;

  // Fault detection and writeback data selection ahead of the register.
  always_comb begin
    fault     = 1'b0;
    next_data = 32'h0000_0000;
    if (wb_sel == SEL_LOAD) begin
      fault = load_is_fault(funct3, alu_result[1:0]);
    end else begin
      fault = 1'b0;
    end
    case (wb_sel)
      SEL_ALU:  next_data = alu_result;
      SEL_LOAD: next_data = fault ? 32'h0000_0000
                                  : extract_load(funct3, alu_result[1:0], mem_read_data);
      SEL_PC4:  next_data = pc_plus4;
      default:  next_data = 32'h0000_0000;
    endcase
  end

  // MEM/WB registers and retire counter; rst > flush > stall > load.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid     <= 1'b0;
      wb_we        <= 1'b0;
      wb_rd        <= 5'd0;
      wb_data      <= 32'h0000_0000;
      load_fault   <= 1'b0;
      retire_count <= '0;
    end else if (flush) begin
      wb_valid   <= 1'b0;
      wb_we      <= 1'b0;
      wb_rd      <= 5'd0;
      wb_data    <= 32'h0000_0000;
      load_fault <= 1'b0;
    end else if (!stall) begin
      wb_valid   <= in_valid;
      wb_we      <= in_valid & reg_write & (rd_addr != 5'd0) & ~fault;
      wb_rd      <= rd_addr;
      wb_data    <= next_data;
      load_fault <= in_valid & fault;
      if (in_valid) begin
        retire_count <= retire_count + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: spec-level model compared every cycle,
// plus hand-computed literal expectations for the directed vectors.
module tb_mem_wb_stage;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst, stall, flush, in_valid, reg_write;
  logic [31:0]   alu_result, mem_read_data, pc_plus4;
  logic [4:0]    rd_addr;
  logic [1:0]    wb_sel;
  logic [2:0]    funct3;
  logic          wb_valid, wb_we, load_fault;
  logic [4:0]    wb_rd;
  logic [31:0]   wb_data;
  logic [CW-1:0] retire_count;

  int passes = 0;
  int total  = 0;
  bit chk_en = 1'b0;

  logic        e_valid, e_we, e_fault;
  logic [4:0]  e_rd;
  logic [31:0] e_data;
  int          e_cnt;

  always #5 clk = ~clk;

  mem_wb_stage #(.CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .alu_result(alu_result), .mem_read_data(mem_read_data), .pc_plus4(pc_plus4),
    .rd_addr(rd_addr), .reg_write(reg_write), .wb_sel(wb_sel), .funct3(funct3),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .load_fault(load_fault), .retire_count(retire_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Access size in bytes: 1, 2 or 4; codes 3, 6, 7 are not loads.
  function automatic bit model_fault(input logic [2:0] f3, input logic [1:0] off);
    int nbytes;
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
    nbytes = 1 << f3[1:0];
    return (int'(off) % nbytes) != 0;
  endfunction

  function automatic logic [31:0] model_data(input logic [1:0] sel, input logic [2:0] f3,
      input logic [31:0] addr, input logic [31:0] word, input logic [31:0] pc);
    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;
    if (sel == 2'd0) return addr;
    if (sel == 2'd2) return pc;
    if (sel == 2'd3) return 32'h0;
    if (model_fault(f3, addr[1:0])) return 32'h0;
    sh = word >> (8 * int'(addr[1:0]));
    b  = sh[7:0];
    h  = sh[15:0];
    if (f3 == 3'd0) return 32'(int'($signed(b)));
    if (f3 == 3'd4) return 32'(b);
    if (f3 == 3'd1) return 32'(int'($signed(h)));
    if (f3 == 3'd5) return 32'(h);
    return word;
  endfunction

  // Reference model of the stage's registered state.
  always @(posedge clk) begin
    if (rst) begin
      e_valid <= 1'b0; e_we <= 1'b0; e_rd <= 5'd0; e_data <= 32'h0; e_fault <= 1'b0;
      e_cnt   <= 0;
    end else if (flush) begin
      e_valid <= 1'b0; e_we <= 1'b0; e_rd <= 5'd0; e_data <= 32'h0; e_fault <= 1'b0;
    end else if (!stall) begin
      e_valid <= in_valid;
      e_rd    <= rd_addr;
      e_data  <= model_data(wb_sel, funct3, alu_result, mem_read_data, pc_plus4);
      e_we    <= in_valid && reg_write && rd_addr != 5'd0 &&
                 !(wb_sel == 2'd1 && model_fault(funct3, alu_result[1:0]));
      e_fault <= in_valid && wb_sel == 2'd1 && model_fault(funct3, alu_result[1:0]);
      if (in_valid) e_cnt <= (e_cnt + 1) % (1 << CW);
    end
  end

  // Every-cycle comparison of DUT against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("valid", 32'(wb_valid), 32'(e_valid));
      chk("we", 32'(wb_we), 32'(e_we));
      chk("rd", 32'(wb_rd), 32'(e_rd));
      chk("data", wb_data, e_data);
      chk("fault", 32'(load_fault), 32'(e_fault));
      chk("count", 32'(retire_count), 32'(e_cnt));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] sel, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [4:0] rd, input logic rw);
    in_valid = 1'b1; wb_sel = sel; funct3 = f3; alu_result = addr; rd_addr = rd; reg_write = rw;
    tick();
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; in_valid = 1'b0; reg_write = 1'b0;
    alu_result = 32'h0; mem_read_data = 32'h0; pc_plus4 = 32'h0;
    rd_addr = 5'd0; wb_sel = 2'd0; funct3 = 3'd0;
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("idle_valid", 32'(wb_valid), 32'h0);
    chk("idle_count", 32'(retire_count), 32'h0);

    pc_plus4 = 32'h0000_0104;
    issue(2'b00, 3'd0, 32'h1234_5678, 5'd5, 1'b1);
    chk("alu_data", wb_data, 32'h1234_5678);
    chk("alu_we", 32'(wb_we), 32'h1);
    chk("alu_rd", 32'(wb_rd), 32'h5);
    chk("alu_count", 32'(retire_count), 32'h1);

    mem_read_data = 32'h80FF_7F01;
    issue(2'b01, 3'b000, 32'h0000_1003, 5'd6, 1'b1);
    chk("lb_off3", wb_data, 32'hFFFF_FF80);
    issue(2'b01, 3'b100, 32'h0000_1003, 5'd6, 1'b1);
    chk("lbu_off3", wb_data, 32'h0000_0080);
    issue(2'b01, 3'b001, 32'h0000_1002, 5'd6, 1'b1);
    chk("lh_off2", wb_data, 32'hFFFF_80FF);
    issue(2'b01, 3'b101, 32'h0000_1000, 5'd6, 1'b1);
    chk("lhu_off0", wb_data, 32'h0000_7F01);
    issue(2'b01, 3'b010, 32'h0000_1000, 5'd6, 1'b1);
    chk("lw_off0", wb_data, 32'h80FF_7F01);
    chk("lw_we", 32'(wb_we), 32'h1);

    issue(2'b01, 3'b010, 32'h0000_1002, 5'd6, 1'b1);
    chk("lw_mis_fault", 32'(load_fault), 32'h1);
    chk("lw_mis_we", 32'(wb_we), 32'h0);
    chk("lw_mis_data", wb_data, 32'h0);
    issue(2'b01, 3'b001, 32'h0000_1001, 5'd6, 1'b1);
    chk("lh_mis_fault", 32'(load_fault), 32'h1);
    issue(2'b01, 3'b011, 32'h0000_1000, 5'd6, 1'b1);
    chk("f3_011_fault", 32'(load_fault), 32'h1);
    issue(2'b01, 3'b110, 32'h0000_1000, 5'd6, 1'b1);
    chk("f3_110_fault", 32'(load_fault), 32'h1);
    issue(2'b01, 3'b100, 32'h0000_1001, 5'd6, 1'b1);
    chk("lbu_off1", wb_data, 32'h0000_007F);

    issue(2'b00, 3'd0, 32'h0000_000A, 5'd9, 1'b1);
    chk("pre_stall", wb_data, 32'h0000_000A);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      issue(2'b10, 3'd0, 32'h0000_0055 + 32'(i), 5'd7, 1'b1);
      chk("stall_data", wb_data, 32'h0000_000A);
      chk("stall_rd", 32'(wb_rd), 32'h9);
    end
    flush = 1'b1;
    tick();
    chk("flush_valid", 32'(wb_valid), 32'h0);
    chk("flush_we", 32'(wb_we), 32'h0);
    flush = 1'b0; stall = 1'b0;

    issue(2'b00, 3'd0, 32'h0000_0099, 5'd0, 1'b1);
    chk("rd0_we", 32'(wb_we), 32'h0);
    chk("rd0_data", wb_data, 32'h0000_0099);
    issue(2'b10, 3'd0, 32'h0000_0099, 5'd1, 1'b1);
    chk("jal_data", wb_data, 32'h0000_0104);
    issue(2'b11, 3'd0, 32'h0000_0099, 5'd1, 1'b1);
    chk("sel11_data", wb_data, 32'h0);
    issue(2'b00, 3'd0, 32'h0000_0042, 5'd3, 1'b0);
    chk("no_rw_we", 32'(wb_we), 32'h0);

    in_valid = 1'b0;
    tick();
    chk("bubble_valid", 32'(wb_valid), 32'h0);

    issue(2'b00, 3'd0, 32'h0000_0077, 5'd4, 1'b1);
    rst = 1'b1; stall = 1'b1; flush = 1'b1;
    tick();
    chk("rst_data", wb_data, 32'h0);
    chk("rst_count", 32'(retire_count), 32'h0);
    rst = 1'b0; stall = 1'b0; flush = 1'b0;

    for (int i = 0; i < 17; i++) issue(2'b00, 3'd0, 32'(i), 5'd2, 1'b1);
    chk("wrap_count", 32'(retire_count), 32'h1);
    in_valid = 1'b0;
    tick();
    tick();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Pipeline stage directly downstream of the memory stage: captures the memory-stage results into the MEM/WB boundary and produces the register-file write port.
- Performs RV32I load alignment and extension (LB/LH/LW/LBU/LHU) on the raw data-memory word.
- Selects the writeback source (ALU result, load data, or PC+4).
- Provides stall, flush, a load-fault flag and a retired-instruction counter.

Parameters:
- CNT_WIDTH, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- stall  input  1  hold all pipeline registers and counter
- flush  input  1  insert bubble (registered entry becomes invalid)
- in_valid  input  1  memory-stage slot holds a real instruction
- alu_result  input  32  ALU result / effective address; bits [1:0] give the byte offset for loads
- mem_read_data  input  32  raw word from the memory stage's read_data
- pc_plus4  input  32  return address for JAL/JALR
- rd_addr  input  5  destination register
- reg_write  input  1  instruction writes rd
- wb_sel  input  2  00 = ALU, 01 = load, 10 = PC+4, 11 = reserved
- funct3  input  3  load size/sign code
- wb_valid  output  1  registered slot valid
- wb_we  output  1  register-file write enable
- wb_rd  output  5  register-file write address
- wb_data  output  32  register-file write data
- load_fault  output  1  registered load was misaligned or had an illegal funct3
- retire_count  output  CNT_WIDTH  number of instructions accepted into this stage

Behaviour:
- Reset (rst=1 at a rising edge): wb_valid, wb_we, wb_rd, wb_data, load_fault and retire_count all 0. Reset has priority over flush and stall. Reset asserted mid-stream discards the held entry.
- Latency: one cycle. Inputs are sampled at the rising edge and the outputs are all registered. wb_data is computed before the register; there is no combinational input-to-output path.
- Update priority per edge: rst > flush > stall > normal load.
- flush=1: wb_valid, wb_we and load_fault go to 0. wb_rd and wb_data go to 0. The counter does not increment. Flush wins over a simultaneous stall.
- stall=1 (no flush): every output register and the counter hold their values.
- Normal: wb_valid <= in_valid; wb_rd <= rd_addr; wb_data <= selected value.
  - wb_we <= in_valid & reg_write & (rd_addr != 0) & ~fault.
  - load_fault <= in_valid & fault.
- fault is defined only when wb_sel=01, and is 1 for any of:
  - funct3 in {011, 110, 111} (illegal load code)
  - LH/LHU with offset[0]=1
  - LW with offset != 0
- Load extraction, with off = alu_result[1:0]:
  - LB (000) / LBU (100): byte = mem_read_data[8*off+7 : 8*off]; sign-extend for LB, zero-extend for LBU.
  - LH (001) / LHU (101): half = off[1] ? [31:16] : [15:0]; sign- or zero-extend accordingly.
  - LW (010): the full word.
  - When fault=1, the load value is 0.
- wb_sel=11 selects 0. The write enable is unaffected, but decode never issues this code.
- rd_addr=0 never produces wb_we=1. wb_data still holds the computed value.
- retire_count increments by 1 on each normal-load edge with in_valid=1. It wraps from all-ones to 0 with no flag.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then in_valid=0 -> all outputs 0, retire_count stays 0.
- ALU writeback: wb_sel=00, alu_result=0x1234_5678, rd=5, reg_write=1 -> next cycle wb_we=1, wb_rd=5, wb_data=0x1234_5678, retire_count=1.
- Load alignment, mem_read_data=0x80FF_7F01:
  - LB off=3 -> 0xFFFF_FF80
  - LBU off=3 -> 0x0000_0080
  - LH off=2 -> 0xFFFF_80FF
  - LHU off=0 -> 0x0000_7F01
  - LW off=0 -> 0x80FF_7F01
- Faults:
  - LW off=2 -> load_fault=1, wb_we=0, wb_data=0
  - LH off=1 -> load_fault=1
  - funct3=011 with wb_sel=01 -> load_fault=1
- Stall/flush:
  - Load an entry (wb_data=0xA), then stall for 3 cycles while the inputs change -> outputs and counter hold.
  - Assert flush and stall together -> wb_valid=0, wb_we=0, counter unchanged.
- Edge cases:
  - rd_addr=0 with reg_write=1 -> wb_we=0.
  - JAL with wb_sel=10 and pc_plus4=0x104 -> wb_data=0x104.
  - CNT_WIDTH=4 with 17 accepted instructions -> retire_count=1 (wrap).
